token_gate: RTL
===============

# token_gate

Upstream front-end of the time-access controller. Authenticates a user's 3-bit token against the system token, runs the 8-bit time base, and on a successful match issues the one-cycle `request` / `confirm` pair with a stable `TimeData` snapshot for the controller's P/Q registers. Repeated failures lock the gate for a fixed number of cycles.

## Interface

Parameters:
- `MAX_TRIES`, 3: failed token attempts that trigger lockout. Legal range 1..3.
- `LOCK_CYCLES`, 16: number of cycles spent in LOCKOUT.
- `TIMEOUT`, 32: consecutive token-less cycles in WAIT_TOKEN before abandoning.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `system_token`, in, 3: reference token, static during operation.
- `user_token`, in, 3: presented token, sampled only when `token_valid`=1.
- `token_valid`, in, 1: user presents `user_token` this cycle.
- `access_req`, in, 1: user starts an access attempt.
- `time_tick`, in, 1: time-base increment enable.
- `request`, out, 1: one-cycle pulse, consumed by the controller.
- `confirm`, out, 1: one-cycle pulse, the cycle after `request`.
- `TimeData`, out, 8: time snapshot, stable from the `request` cycle until the next grant.
- `busy`, out, 1: high when state ≠ IDLE.
- `locked`, out, 1: high when state = LOCKOUT.
- `fail_count`, out, 2: current count of failed attempts.

## Operation

- Time base: 8-bit counter `tcnt`, +1 on each cycle with `time_tick`=1; wraps 255→0. It runs freely in every state.
- States: IDLE, WAIT_TOKEN, REQ, CONF, LOCKOUT. Outputs are Moore-decoded from the registered state: `request`=(REQ), `confirm`=(CONF), `busy`, `locked`.
- IDLE:
  - `access_req`=1 → WAIT_TOKEN; `wait_cnt` cleared.
  - `token_valid` is ignored in IDLE, even when it coincides with `access_req`.
- WAIT_TOKEN:
  - `token_valid` with `user_token`==`system_token` → REQ. `TimeData` ← current `tcnt` value (pre-increment); `fail_count` ← 0.
  - `token_valid` with a mismatch → `fail_count`+1 and `wait_cnt` ← 0.
    - If the new count equals `MAX_TRIES` → LOCKOUT with `lock_cnt` ← 0.
    - Otherwise stay in WAIT_TOKEN.
  - No `token_valid` → `wait_cnt`+1.
    - If `wait_cnt`==`TIMEOUT`-1 → IDLE. Timeout does not change `fail_count`.
  - `access_req` is ignored.
- REQ → CONF → IDLE unconditionally. All inputs except `reset` and `time_tick` are ignored.
- LOCKOUT:
  - `lock_cnt`+1 each cycle.
  - When `lock_cnt`==`LOCK_CYCLES`-1 → IDLE with `fail_count` ← 0.
  - `access_req` and `token_valid` are ignored.
- `fail_count` persists across timeouts and IDLE. It clears only on a match, on lockout exit, or on reset.
- Reset (`reset`=0 at a clock edge), in any state including mid-grant or mid-lockout:
  - state ← IDLE.
  - `tcnt`, `TimeData`, `wait_cnt`, `lock_cnt`, `fail_count` ← 0.
  - All outputs are 0 from the following cycle.
  - A reset during REQ suppresses the pending `confirm`.

## Timing

- Matching token sampled at edge k → `request`=1 during cycle k+1, `confirm`=1 during cycle k+2, `busy`=0 from cycle k+3.
- `access_req` at edge k → `busy`=1 from cycle k+1. The earliest usable `token_valid` is at edge k+1.
- `TimeData` changes only at the edge entering REQ. It is stable during REQ and CONF and held afterwards.
- WAIT_TOKEN with no tokens lasts exactly `TIMEOUT` cycles.
- LOCKOUT lasts exactly `LOCK_CYCLES` cycles. `locked` is high for exactly those cycles.
- Mismatch #`MAX_TRIES` at edge k → `locked`=1 from cycle k+1.
- A new `access_req` is accepted during CONF's following IDLE cycle at the earliest. Back-to-back grants are therefore 4 cycles apart minimum.

## Test plan

- Reset, then hold `time_tick`=1 for 300 cycles → `TimeData`=0, all outputs 0; `tcnt` wraps 255→0.
- `system_token`=3'b101, `access_req`, then `user_token`=3'b101 with `token_valid` when `tcnt`=0x2A → `request` pulses 1 cycle with `TimeData`=0x2A, then `confirm` pulses 1 cycle, then `busy`=0, `fail_count`=0.
- Three mismatches (3'b000) in one attempt → `fail_count` 1, 2, then `locked`=1 for exactly 16 cycles. `access_req`/`token_valid` sent during lockout produce no pulse. Afterwards `fail_count`=0.
- `access_req`, then no token → `busy` stays high exactly 32 cycles, then IDLE. A 1-fail count survives the timeout, and the next successful match clears it.
- `token_valid`+`access_req` with a correct token in the same IDLE cycle → no grant; the gate enters WAIT_TOKEN only.
- Pull `reset` low during REQ → no `confirm`, and all outputs and `TimeData` = 0 on the next cycle.

Source files
------------

// File: rtl/token_gate.sv
// token_gate: authenticates a 3-bit user token against the system token,
// runs the free-running 8-bit time base, issues the request/confirm grant
// pulses with a TimeData snapshot, and locks out after repeated failures.
module token_gate #(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] system_token,
  input  logic [2:0] user_token,
  input  logic       token_valid,
  input  logic       access_req,
  input  logic       time_tick,
  output logic       request,
  output logic       confirm,
  output logic [7:0] TimeData,
  output logic       busy,
  output logic       locked,
  output logic [1:0] fail_count
);

  // Counter widths sized so the terminal value (N-1) always fits.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_REQ     = 3'd2,
    S_CONF    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    time_data_q, time_data_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]    fail_q, fail_d;
  logic          request_q, request_d;
  logic          confirm_q, confirm_d;
  logic          busy_q, busy_d;
  logic          locked_q, locked_d;
  logic          token_match_s;

  assign token_match_s = (user_token == system_token);

  // Next-state, counter and snapshot logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q + {7'd0, time_tick};
    time_data_d = time_data_q;
    wait_cnt_d  = wait_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    fail_d      = fail_q;

    case (state_q)
      S_IDLE: begin
        if (access_req) begin
          state_d    = S_WAIT;
          wait_cnt_d = {WW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (token_valid && token_match_s) begin
          state_d     = S_REQ;
          time_data_d = tcnt_q;
          fail_d      = 2'd0;
        end else if (token_valid) begin
          fail_d     = fail_q + 2'd1;
          wait_cnt_d = {WW{1'b0}};
          if ((fail_q + 2'd1) == TRIES_MAX) begin
            state_d    = S_LOCKOUT;
            lock_cnt_d = {LW{1'b0}};
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_REQ: begin
        state_d = S_CONF;
      end
      S_CONF: begin
        state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        lock_cnt_d = lock_cnt_q + LW'(1);
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = S_IDLE;
          fail_d  = 2'd0;
        end else begin
          state_d = S_LOCKOUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    request_d = (state_d == S_REQ);
    confirm_d = (state_d == S_CONF);
    busy_d    = (state_d != S_IDLE);
    locked_d  = (state_d == S_LOCKOUT);
  end

  // State, counters, snapshot and output flops with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tcnt_q      <= 8'd0;
      time_data_q <= 8'd0;
      wait_cnt_q  <= {WW{1'b0}};
      lock_cnt_q  <= {LW{1'b0}};
      fail_q      <= 2'd0;
      request_q   <= 1'b0;
      confirm_q   <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      time_data_q <= time_data_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_q      <= fail_d;
      request_q   <= request_d;
      confirm_q   <= confirm_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
    end
  end

  assign request    = request_q;
  assign confirm    = confirm_q;
  assign TimeData   = time_data_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail_count = fail_q;

endmodule
